// File: rtl/machine_mode_types_1_12_pkg.sv
// Machine-mode CSR field layouts and mtvec mode encodings shared by the
// v1.12 privilege block.
package machine_mode_types_1_12_pkg;

    typedef struct packed {
        logic [29:0] base;
        logic [1:0]  mode;
    } mtvec_t;

    typedef struct packed {
        logic        interrupt;
        logic [30:0] cause;
    } mcause_t;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/priv_1_12_trap_target.sv
// Redirect target for a trap or trap return. Purely combinational, so an
// S-mode stvec/sepc path can reuse it unchanged.
module priv_1_12_trap_target
    import machine_mode_types_1_12_pkg::*;
(
    input  logic        is_intr,
    input  logic        is_dret,
    input  mtvec_t      mtvec,
    input  mcause_t     mcause,
    input  logic [31:0] mepc,
    input  logic [31:0] dpc,
    output logic [31:0] target
);

    logic [31:0] base;
    logic        unused_bits;

    assign base = {mtvec.base, 2'b00};

    // Cause bit 30 is shifted out of the 32-bit offset; return targets drop [1:0].
    assign unused_bits = ^{mcause.cause[30], mepc[1:0], dpc[1:0]};

    // NOTE: assign a default first so no path through the block leaves target
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        target = {mepc[31:2], 2'b00};
        if (is_intr) begin
            if (mtvec.mode == MTVEC_VECTORED && mcause.interrupt)
                target = base + {mcause.cause[29:0], 2'b00};
            else
                target = base;
        end else if (is_dret) begin
            target = {dpc[31:2], 2'b00};
        end
    end

endmodule

// File: rtl/priv_1_12_pipe_control.sv
// Holds trap / trap-return redirects until the pipeline is hazard-free, then
// emits a one-cycle insert_pc strobe with the latched target to fetch.
module priv_1_12_pipe_control
    import machine_mode_types_1_12_pkg::*;
#(
    parameter logic [31:0] RESET_PC_VAL = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        intr,
    input  logic        mret,
    input  logic        sret,
    input  logic        dret,
    input  logic        pipe_clear,
    input  mtvec_t      curr_mtvec,
    input  logic [31:0] curr_mepc,
    input  logic [31:0] curr_dpc,
    input  mcause_t     next_mcause,
    output logic        insert_pc,
    output logic [31:0] priv_pc,
    output logic        redirect_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_INSERT} state_e;
    typedef enum logic [1:0] {REQ_NONE, REQ_INTR, REQ_MRET, REQ_DRET} req_kind_e;

    state_e      state, next_state;
    req_kind_e   new_req, pend_kind;
    logic [31:0] new_target, pend_target, next_target;
    logic        take_new;
    logic        unused_sret;

    // No S-mode in this configuration, so sret never redirects.
    assign unused_sret = sret;

    always_comb begin
        new_req = REQ_NONE;
        if (intr)      new_req = REQ_INTR;
        else if (dret) new_req = REQ_DRET;
        else if (mret) new_req = REQ_MRET;
    end

    priv_1_12_trap_target u_trap_target (
        .is_intr (new_req == REQ_INTR),
        .is_dret (new_req == REQ_DRET),
        .mtvec   (curr_mtvec),
        .mcause  (next_mcause),
        .mepc    (curr_mepc),
        .dpc     (curr_dpc),
        .target  (new_target)
    );

    // While pending, a return never displaces a pending trap.
    always_comb begin
        take_new = 1'b0;
        if (state == ST_PENDING)
            take_new = (new_req == REQ_INTR) ||
                       (new_req != REQ_NONE && pend_kind != REQ_INTR);
        else
            take_new = (new_req != REQ_NONE);

        next_target = take_new ? new_target : pend_target;

        if (state == ST_PENDING || take_new)
            next_state = pipe_clear ? ST_INSERT : ST_PENDING;
        else
            next_state = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= ST_IDLE;
            pend_kind     <= REQ_NONE;
            pend_target   <= '0;
            priv_pc       <= RESET_PC_VAL;
            insert_pc     <= 1'b0;
            redirect_busy <= 1'b0;
        end else begin
            state         <= next_state;
            insert_pc     <= (next_state == ST_INSERT);
            redirect_busy <= (next_state == ST_PENDING);
            if (take_new) begin
                pend_kind   <= new_req;
                pend_target <= new_target;
            end
            if (next_state == ST_INSERT)
                priv_pc <= next_target;
        end
    end

endmodule

// File: tb/tb_priv_1_12_pipe_control.sv
// Directed bench for priv_1_12_pipe_control: one task per scenario, each with
// hand-computed expected redirect targets and pulse timing.
module tb_priv_1_12_pipe_control;

    localparam logic [31:0] RST_PC = 32'hABCD_0000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        intr, mret, sret, dret, pipe_clear;
    logic [31:0] curr_mtvec, curr_mepc, curr_dpc, next_mcause;
    logic        insert_pc;
    logic [31:0] priv_pc;
    logic        redirect_busy;

    int n_checks = 0;
    int n_fail   = 0;

    priv_1_12_pipe_control #(.RESET_PC_VAL(RST_PC)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .intr          (intr),
        .mret          (mret),
        .sret          (sret),
        .dret          (dret),
        .pipe_clear    (pipe_clear),
        .curr_mtvec    (curr_mtvec),
        .curr_mepc     (curr_mepc),
        .curr_dpc      (curr_dpc),
        .next_mcause   (next_mcause),
        .insert_pc     (insert_pc),
        .priv_pc       (priv_pc),
        .redirect_busy (redirect_busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        intr = 1'b0; mret = 1'b0; sret = 1'b0; dret = 1'b0; pipe_clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        curr_mtvec = 32'h0; curr_mepc = 32'h0; curr_dpc = 32'h0; next_mcause = 32'h0;
        nRST = 1'b0;
        #12;
        n_checks++;
        if (insert_pc !== 1'b0 || redirect_busy !== 1'b0 || priv_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_values: insert=%b busy=%b pc=%h expected 0 0 %h",
                     insert_pc, redirect_busy, priv_pc, RST_PC);
        end
        tick();
        nRST = 1'b1;
        tick();
        n_checks++;
        if (insert_pc !== 1'b0 || priv_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_release: insert=%b pc=%h expected 0 %h", insert_pc, priv_pc, RST_PC);
        end
    endtask

    task automatic test_direct_trap();
        curr_mtvec = 32'h0000_0100;
        next_mcause = 32'h8000_0003;
        intr = 1'b1; pipe_clear = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (insert_pc !== 1'b1 || priv_pc !== 32'h0000_0100 || redirect_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_trap: insert=%b busy=%b pc=%h expected 1 0 00000100",
                     insert_pc, redirect_busy, priv_pc);
        end
        tick();
        n_checks++;
        if (insert_pc !== 1'b0 || priv_pc !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL direct_single_pulse: insert=%b pc=%h expected 0 00000100", insert_pc, priv_pc);
        end
    endtask

    // Each row: mtvec, mcause, expected target; intr with pipe_clear, one idle gap.
    task automatic test_vectored();
        logic [31:0] tv [5];
        logic [31:0] tc [5];
        logic [31:0] te [5];
        tv[0] = 32'h0000_0201; tc[0] = 32'h8000_0007; te[0] = 32'h0000_021C;
        tv[1] = 32'h0000_0201; tc[1] = 32'h0000_0002; te[1] = 32'h0000_0200;
        tv[2] = 32'h0000_0203; tc[2] = 32'h8000_0005; te[2] = 32'h0000_0200;
        tv[3] = 32'hFFFF_FFF1; tc[3] = 32'h8000_0008; te[3] = 32'h0000_0010;
        tv[4] = 32'h0000_0201; tc[4] = 32'hC000_0001; te[4] = 32'h0000_0204;
        for (int i = 0; i < 5; i++) begin
            curr_mtvec = tv[i]; next_mcause = tc[i];
            intr = 1'b1; pipe_clear = 1'b1;
            tick();
            idle_inputs();
            n_checks++;
            if (insert_pc !== 1'b1 || priv_pc !== te[i]) begin
                n_fail++;
                $display("FAIL vectored_%0d: insert=%b pc=%h expected 1 %h", i, insert_pc, priv_pc, te[i]);
            end
            tick();
        end
    endtask

    task automatic test_stalled_mret();
        curr_mepc = 32'h0000_1003;
        mret = 1'b1; pipe_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            mret = 1'b0;
            n_checks++;
            if (redirect_busy !== 1'b1 || insert_pc !== 1'b0) begin
                n_fail++;
                $display("FAIL stalled_busy_%0d: busy=%b insert=%b expected 1 0", i, redirect_busy, insert_pc);
            end
        end
        curr_mepc = 32'h0000_2000;
        pipe_clear = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (insert_pc !== 1'b1 || priv_pc !== 32'h0000_1000 || redirect_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stalled_insert: insert=%b busy=%b pc=%h expected 1 0 00001000",
                     insert_pc, redirect_busy, priv_pc);
        end
        tick();
        n_checks++;
        if (insert_pc !== 1'b0 || priv_pc !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL stalled_hold: insert=%b pc=%h expected 0 00001000", insert_pc, priv_pc);
        end
    endtask

    task automatic test_priority();
        int pulses;
        // Pending dret overridden by intr.
        curr_dpc = 32'h0000_3000; curr_mtvec = 32'h0000_0100; next_mcause = 32'h0000_0002;
        dret = 1'b1;
        tick();
        dret = 1'b0; intr = 1'b1;
        tick();
        intr = 1'b0;
        n_checks++;
        if (redirect_busy !== 1'b1 || insert_pc !== 1'b0) begin
            n_fail++;
            $display("FAIL override_pending: busy=%b insert=%b expected 1 0", redirect_busy, insert_pc);
        end
        pipe_clear = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pipe_clear = 1'b0;
            if (insert_pc === 1'b1) begin
                pulses++;
                n_checks++;
                if (priv_pc !== 32'h0000_0100) begin
                    n_fail++;
                    $display("FAIL override_target: pc=%h expected 00000100", priv_pc);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL override_pulses: got %0d expected 1", pulses);
        end

        // Pending intr drops a later mret.
        curr_mtvec = 32'h0000_0140; curr_mepc = 32'h0000_4000;
        intr = 1'b1;
        tick();
        intr = 1'b0; mret = 1'b1;
        tick();
        mret = 1'b0; pipe_clear = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (insert_pc !== 1'b1 || priv_pc !== 32'h0000_0140) begin
            n_fail++;
            $display("FAIL intr_keeps_mret_dropped: insert=%b pc=%h expected 1 00000140", insert_pc, priv_pc);
        end
        tick();

        // Same-cycle intr+mret: trap wins.
        curr_mtvec = 32'h0000_0180;
        intr = 1'b1; mret = 1'b1; pipe_clear = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (insert_pc !== 1'b1 || priv_pc !== 32'h0000_0180) begin
            n_fail++;
            $display("FAIL same_cycle_intr_mret: insert=%b pc=%h expected 1 00000180", insert_pc, priv_pc);
        end
        tick();

        // Same-cycle dret+mret: dret wins.
        dret = 1'b1; mret = 1'b1; pipe_clear = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (insert_pc !== 1'b1 || priv_pc !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL same_cycle_dret_mret: insert=%b pc=%h expected 1 00003000", insert_pc, priv_pc);
        end
        tick();

        // Pending mret re-latched by a later dret.
        curr_mepc = 32'h0000_5000; curr_dpc = 32'h0000_6006;
        mret = 1'b1;
        tick();
        mret = 1'b0; dret = 1'b1; pipe_clear = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (insert_pc !== 1'b1 || priv_pc !== 32'h0000_6004) begin
            n_fail++;
            $display("FAIL return_relatch: insert=%b pc=%h expected 1 00006004", insert_pc, priv_pc);
        end
        tick();

        // sret alone does nothing.
        sret = 1'b1; pipe_clear = 1'b1;
        tick();
        n_checks++;
        if (insert_pc !== 1'b0 || redirect_busy !== 1'b0 || priv_pc !== 32'h0000_6004) begin
            n_fail++;
            $display("FAIL sret_ignored: insert=%b busy=%b pc=%h expected 0 0 00006004",
                     insert_pc, redirect_busy, priv_pc);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (insert_pc !== 1'b0) begin
            n_fail++;
            $display("FAIL sret_no_pulse: insert=%b expected 0", insert_pc);
        end
    endtask

    task automatic test_back_to_back();
        curr_mepc = 32'h0000_7000;
        mret = 1'b1; pipe_clear = 1'b1;
        tick();
        n_checks++;
        if (insert_pc !== 1'b1 || priv_pc !== 32'h0000_7000) begin
            n_fail++;
            $display("FAIL b2b_first: insert=%b pc=%h expected 1 00007000", insert_pc, priv_pc);
        end
        curr_mepc = 32'h0000_8000;
        tick();
        idle_inputs();
        n_checks++;
        if (insert_pc !== 1'b1 || priv_pc !== 32'h0000_8000) begin
            n_fail++;
            $display("FAIL b2b_second: insert=%b pc=%h expected 1 00008000", insert_pc, priv_pc);
        end
        tick();
        n_checks++;
        if (insert_pc !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: insert=%b expected 0", insert_pc);
        end
    endtask

    task automatic test_reset_pending();
        curr_mepc = 32'h0000_9000;
        mret = 1'b1; pipe_clear = 1'b0;
        tick();
        mret = 1'b0;
        n_checks++;
        if (redirect_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pending_setup: busy=%b expected 1", redirect_busy);
        end
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (redirect_busy !== 1'b0 || insert_pc !== 1'b0 || priv_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL rst_async: busy=%b insert=%b pc=%h expected 0 0 %h",
                     redirect_busy, insert_pc, priv_pc, RST_PC);
        end
        tick();
        nRST = 1'b1;
        pipe_clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (insert_pc !== 1'b0 || redirect_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_pulse_%0d: insert=%b busy=%b expected 0 0", i, insert_pc, redirect_busy);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_direct_trap();
        test_vectored();
        test_stalled_mret();
        test_priority();
        test_back_to_back();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
